// File: rtl/debounce_fsm.sv
// Switch debouncer: 2-flop synchronizer, free-running tick generator and a
// 4-state Moore FSM that needs CONFIRM stable ticks before moving db.
module debounce_fsm #(
  parameter int unsigned TICK_BITS = 17,
  parameter int unsigned CONFIRM   = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db,
  output logic tick,
  output logic waiting
);

  typedef enum logic [1:0] {
    StZero  = 2'b00,
    StWait1 = 2'b01,
    StOne   = 2'b10,
    StWait0 = 2'b11
  } state_e;

  localparam logic [3:0] ConfirmLast = 4'(CONFIRM - 1);

  logic [1:0]           r_sync;
  logic [TICK_BITS-1:0] r_tick_cnt;
  logic [3:0]           r_cnt;
  state_e               r_state;

  logic                 w_sw_s;
  logic                 w_tick;
  logic [3:0]           w_cnt_d;
  state_e               w_state_d;

  assign w_sw_s = r_sync[1];
  assign w_tick = &r_tick_cnt;
  assign tick   = w_tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync     <= 2'b00;
      r_tick_cnt <= '0;
      r_cnt      <= 4'd0;
      r_state    <= StZero;
    end else begin
      r_sync     <= {r_sync[0], sw};
      r_tick_cnt <= r_tick_cnt + TICK_BITS'(1);
      r_cnt      <= w_cnt_d;
      r_state    <= w_state_d;
    end
  end

  // An input flip back to the current db level aborts the wait, even on a tick.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StZero: begin
        if (w_sw_s) begin
          w_state_d = StWait1;
          w_cnt_d   = 4'd0;
        end
      end
      StWait1: begin
        if (!w_sw_s) begin
          w_state_d = StZero;
        end else if (w_tick) begin
          if (r_cnt == ConfirmLast) w_state_d = StOne;
          else                      w_cnt_d   = r_cnt + 4'd1;
        end
      end
      StOne: begin
        if (!w_sw_s) begin
          w_state_d = StWait0;
          w_cnt_d   = 4'd0;
        end
      end
      StWait0: begin
        if (w_sw_s) begin
          w_state_d = StOne;
        end else if (w_tick) begin
          if (r_cnt == ConfirmLast) w_state_d = StZero;
          else                      w_cnt_d   = r_cnt + 4'd1;
        end
      end
      default: w_state_d = StZero;
    endcase
  end

  always_comb begin
    db      = 1'b0;
    waiting = 1'b0;
    case (r_state)
      StOne:   db = 1'b1;
      StWait0: begin
        db      = 1'b1;
        waiting = 1'b1;
      end
      StWait1: waiting = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_debounce_fsm.sv
// Bench for debounce_fsm: directed scenarios plus random switch activity,
// compared against a level/tick-count model of the debounce rules.
module tb_debounce_fsm;

  localparam int unsigned TB     = 3;
  localparam int unsigned CONF   = 3;
  localparam int          PERIOD = 1 << TB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sw = 1'b0;
  logic db, tick, waiting;

  int checks = 0;
  int errors = 0;

  // Model: delayed switch, cycles since reset, settled level, pending flag, ticks seen.
  logic sw_hist [2];
  int   m_cyc;
  logic m_db;
  logic m_wait;
  int   m_seen;

  debounce_fsm #(
    .TICK_BITS(TB),
    .CONFIRM  (CONF)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sw     (sw),
    .db     (db),
    .tick   (tick),
    .waiting(waiting)
  );

  always #5 clk = ~clk;

  function automatic logic m_tick();
    return (m_cyc % PERIOD) == PERIOD - 1;
  endfunction

  // Advance one clock and apply the debounce rules to the model.
  task automatic step();
    logic sws;
    logic tk;
    @(posedge clk);
    if (reset) begin
      sw_hist[0] = 1'b0;
      sw_hist[1] = 1'b0;
      m_cyc  = 0;
      m_db   = 1'b0;
      m_wait = 1'b0;
      m_seen = 0;
    end else begin
      sws = sw_hist[1];
      tk  = m_tick();
      if (!m_wait) begin
        if (sws != m_db) begin
          m_wait = 1'b1;
          m_seen = 0;
        end
      end else if (sws == m_db) begin
        m_wait = 1'b0;
      end else if (tk) begin
        m_seen++;
        if (m_seen == CONF) begin
          m_db   = ~m_db;
          m_wait = 1'b0;
        end
      end
      sw_hist[1] = sw_hist[0];
      sw_hist[0] = sw;
      m_cyc++;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sw    = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (db !== 1'b0 || tick !== 1'b0 || waiting !== 1'b0) begin
      errors++;
      $display("FAIL reset: db=%b tick=%b waiting=%b, required 0 0 0", db, tick, waiting);
    end
  endtask

  task automatic test_idle();
    for (int c = 1; c <= 50; c++) begin
      step();
      checks++;
      if (db !== 1'b0 || waiting !== 1'b0 || tick !== ((c % PERIOD) == PERIOD - 1)) begin
        errors++;
        $display("FAIL idle c=%0d: db=%b waiting=%b tick=%b, required 0 0 %b",
                 c, db, waiting, tick, (c % PERIOD) == PERIOD - 1);
      end
    end
  endtask

  task automatic test_clean_press();
    do_reset();
    for (int c = 1; c <= 8; c++) step();
    sw = 1'b1;
    for (int c = 9; c <= 40; c++) begin
      step();
      checks++;
      if (db !== m_db || waiting !== m_wait || tick !== m_tick()) begin
        errors++;
        $display("FAIL press c=%0d: db=%b waiting=%b tick=%b, required %b %b %b",
                 c, db, waiting, tick, m_db, m_wait, m_tick());
      end
      if (c == 10 || c == 11 || c == 31 || c == 32) begin
        checks++;
        if (waiting !== (c == 11 || c == 31) || db !== (c == 32)) begin
          errors++;
          $display("FAIL press_edge c=%0d: db=%b waiting=%b, required %b %b",
                   c, db, waiting, c == 32, c == 11 || c == 31);
        end
      end
    end
  endtask

  task automatic test_bounce();
    int rose = 0;
    do_reset();
    sw = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c == 10) sw = 1'b0;
      step();
      if (waiting) rose = 1;
      checks++;
      if (db !== m_db || waiting !== m_wait || db !== 1'b0) begin
        errors++;
        $display("FAIL bounce c=%0d: db=%b waiting=%b, required 0 %b", c, db, waiting, m_wait);
      end
    end
    checks++;
    if (rose != 1 || waiting !== 1'b0) begin
      errors++;
      $display("FAIL bounce_wait: rose=%0d waiting=%b, required 1 0", rose, waiting);
    end
  endtask

  task automatic reach_one(input string tag);
    int n = 0;
    sw = 1'b1;
    while (!(m_db && !m_wait) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n >= 200 || db !== 1'b1) begin
      errors++;
      $display("FAIL %s_setup: db=%b after %0d cycles, required 1", tag, db, n);
    end
  endtask

  task automatic test_release_glitch();
    do_reset();
    reach_one("glitch");
    sw = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (c == 12) sw = 1'b1;
      if (c == 14) sw = 1'b0;
      step();
      checks++;
      if (db !== m_db || waiting !== m_wait || tick !== m_tick() || (c < 16 && db !== 1'b1)) begin
        errors++;
        $display("FAIL glitch c=%0d: db=%b waiting=%b tick=%b, required %b %b %b",
                 c, db, waiting, tick, m_db, m_wait, m_tick());
      end
    end
    checks++;
    if (db !== 1'b0) begin
      errors++;
      $display("FAIL glitch_final: db=%b, required 0", db);
    end
  endtask

  task automatic test_reset_mid_wait0();
    do_reset();
    reach_one("midrst");
    sw = 1'b0;
    for (int c = 0; c < 5; c++) step();
    checks++;
    if (db !== 1'b1 || waiting !== 1'b1) begin
      errors++;
      $display("FAIL midrst_wait: db=%b waiting=%b, required 1 1", db, waiting);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (db !== 1'b0 || waiting !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after: db=%b waiting=%b tick=%b, required 0 0 0", db, waiting, tick);
    end
    for (int c = 1; c <= 8; c++) begin
      step();
      checks++;
      if (tick !== (c == 7) || db !== 1'b0) begin
        errors++;
        $display("FAIL midrst_tick c=%0d: tick=%b db=%b, required %b 0", c, tick, db, c == 7);
      end
    end
  endtask

  task automatic test_collision();
    int n = 0;
    do_reset();
    sw = 1'b1;
    // Drop sw two cycles ahead so the synchronized fall meets the third tick.
    while (!(m_wait && m_seen == 2 && (m_cyc % PERIOD) == PERIOD - 3) && n < 200) begin
      step();
      n++;
    end
    sw = 1'b0;
    step();
    step();
    checks++;
    if (n >= 200 || tick !== 1'b1 || waiting !== 1'b1) begin
      errors++;
      $display("FAIL collide_setup: n=%0d tick=%b waiting=%b, required tick 1 waiting 1",
               n, tick, waiting);
    end
    step();
    checks++;
    if (db !== 1'b0 || waiting !== 1'b0 || db !== m_db) begin
      errors++;
      $display("FAIL collide: db=%b waiting=%b, required 0 0", db, waiting);
    end
  endtask

  task automatic test_random();
    int hold = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        sw   = 1'($urandom_range(0, 1));
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 12);
      end
      hold--;
      step();
      checks++;
      if (db !== m_db || waiting !== m_wait || tick !== m_tick()) begin
        errors++;
        $display("FAIL random c=%0d: db=%b waiting=%b tick=%b, required %b %b %b",
                 c, db, waiting, tick, m_db, m_wait, m_tick());
      end
    end
  endtask

  initial begin
    sw_hist[0] = 1'b0;
    sw_hist[1] = 1'b0;
    m_cyc  = 0;
    m_db   = 1'b0;
    m_wait = 1'b0;
    m_seen = 0;
    test_reset();
    test_idle();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_reset_mid_wait0();
    test_collision();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
